uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_arb_pkg.sv | 13 +
 rtl/uart_rr_pick.sv | 28 ++
 rtl/uart_tx_arbiter.sv | 105 ++++++++++
 3 files changed

// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared state type and default sizing for the UART transmit arbiter
package uart_arb_pkg;

    typedef enum logic {
        IDLE,
        GRANT
    } arb_state_t;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_MAX_BURST  = 16;

endpackage

// File: rtl/uart_rr_pick.sv
// uart_rr_pick: combinational round-robin selector, search starts one past the pointer
module uart_rr_pick #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic [$clog2(NUM_REQ)-1:0] idx_o,
    output logic                       any_o
);

    localparam int IW = $clog2(NUM_REQ);

    // scan offsets from farthest to nearest so the nearest valid requester after the pointer wins
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = |req_i;
        for (int k = NUM_REQ; k > 0; k--) begin
            if (req_i[(int'(ptr_i) + k) % NUM_REQ]) begin
                gnt_o = '0;
                gnt_o[(int'(ptr_i) + k) % NUM_REQ] = 1'b1;
                idx_o = IW'((int'(ptr_i) + k) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter input among several requesters
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MAX_BURST  = DEF_MAX_BURST
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          tx_valid,
    output logic [DATA_WIDTH-1:0]         tx_data,
    input  logic                          tx_ready,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_BURST) + 1;

    arb_state_t            state_q, state_d;
    logic [IW-1:0]         grant_q, grant_d;
    logic [IW-1:0]         last_q, last_d;
    logic [NUM_REQ-1:0]    oh_q, oh_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  txv_q, txv_d;
    logic [DATA_WIDTH-1:0] txd_q, txd_d;

    logic [NUM_REQ-1:0]    pick_gnt;
    logic [IW-1:0]         pick_idx;
    logic                  pick_any;
    logic                  can_take;
    logic                  accept;
    logic                  release_now;
    logic [DATA_WIDTH-1:0] beat;

    uart_rr_pick #(
        .NUM_REQ(NUM_REQ)
    ) u_pick (
        .req_i(req_valid),
        .ptr_i(last_q),
        .gnt_o(pick_gnt),
        .idx_o(pick_idx),
        .any_o(pick_any)
    );

    // the output register can take a beat when empty or draining this cycle
    assign can_take    = (state_q == GRANT) && (!txv_q || tx_ready);
    assign req_ready   = can_take ? oh_q : '0;
    assign accept      = |(req_valid & req_ready);
    assign beat        = req_data[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
    assign release_now = accept && (req_last[grant_q] || (cnt_q + CW'(1) == CW'(MAX_BURST)));

    assign tx_valid = txv_q;
    assign tx_data  = txd_q;
    assign grant_id = grant_q;
    assign busy     = (state_q == GRANT);

    // arbitration in IDLE, beat counting and release in GRANT, output register fill/drain
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        oh_d    = oh_q;
        cnt_d   = cnt_q;
        txv_d   = accept ? 1'b1 : (tx_ready ? 1'b0 : txv_q);
        txd_d   = accept ? beat : txd_q;
        if (state_q == IDLE) begin
            state_d = pick_any ? GRANT : IDLE;
            grant_d = pick_any ? pick_idx : grant_q;
            oh_d    = pick_any ? pick_gnt : oh_q;
            cnt_d   = pick_any ? '0 : cnt_q;
        end else begin
            cnt_d   = accept ? cnt_q + CW'(1) : cnt_q;
            state_d = release_now ? IDLE : GRANT;
            last_d  = release_now ? grant_q : last_q;
        end
    end

    // state and datapath registers; reset drops any held beat and grant
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= IW'(NUM_REQ - 1);
            oh_q    <= '0;
            cnt_q   <= '0;
            txv_q   <= 1'b0;
            txd_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            oh_q    <= oh_d;
            cnt_q   <= cnt_d;
            txv_q   <= txv_d;
            txd_q   <= txd_d;
        end
    end

endmodule
